// File: rtl/vec_mem_pkg.sv
// Shared constants and types for the vector memory sequencer.
// Element-to-lane mapping lives here so the datapath and the read-tag logic agree on it.
package vec_mem_pkg;

  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int AW    = 21;
  localparam int IDX_W = $clog2(LANES);

  typedef logic [LANES-1:0][DW-1:0] lane_vec_t;
  typedef logic [IDX_W-1:0]         lane_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

  // Element k of a transfer occupies vector index LANES-1-k; index LANES-1 is the scalar lane.
  function automatic lane_idx_t lane_of(input lane_idx_t elem);
    return lane_idx_t'(LANES - 1) - elem;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line that carries {valid, element index} alongside each RAM read strobe,
// so the tag emerges in the same cycle as the matching read data.
module rd_tag_pipe
  import vec_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_valid,
  input  lane_idx_t i_idx,
  output logic      o_valid,
  output lane_idx_t o_idx
);

  logic [RD_LAT-1:0]            r_valid;
  logic [RD_LAT-1:0][IDX_W-1:0] r_idx;

  generate
    if (RD_LAT == 1) begin : g_single
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_valid <= '0;
        else      r_valid <= i_valid;
      end

      // NOTE: only the valid bits are reset; the index payload is qualified by valid and needs no reset.
      always_ff @(posedge clk) begin
        r_idx <= i_idx;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_valid <= '0;
        else      r_valid <= {r_valid[RD_LAT-2:0], i_valid};
      end

      always_ff @(posedge clk) begin
        r_idx <= {r_idx[RD_LAT-2:0], i_idx};
      end
    end
  endgenerate

  assign o_valid = r_valid[RD_LAT-1];
  assign o_idx   = r_idx[RD_LAT-1];

endmodule

// File: rtl/vec_mem_sequencer.sv
// Serialises 16-lane vector loads/stores onto a single word-wide RAM port and
// reassembles load returns into one vector; holds the core pipeline via stall.
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  lane_vec_t     req_wdata,
  output logic          rsp_valid,
  output lane_vec_t     rsp_rdata,
  output logic          stall,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  seq_state_t    r_state, w_state_n;
  lane_idx_t     r_cnt, w_cnt_n;
  logic          w_accept;

  logic [AW-1:0] r_base;
  logic          r_write;
  lane_vec_t     r_wdata;

  logic [AW-1:0] w_base_sel;
  logic          w_write_sel;
  lane_vec_t     w_wdata_sel;

  logic          r_req_ready, w_req_ready_n;
  logic          r_stall, w_stall_n;
  logic          r_rsp_valid, w_rsp_valid_n;
  lane_vec_t     r_rsp_rdata;
  logic [AW-1:0] r_mem_addr, w_mem_addr_n;
  logic          r_mem_re, w_mem_re_n;
  logic          r_mem_we, w_mem_we_n;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_n;
  lane_idx_t     r_mem_idx;
  logic          w_issue_n;

  lane_vec_t     r_shadow, w_shadow_n;
  logic          w_cap_valid;
  lane_idx_t     w_cap_idx;
  logic          w_cap_last;

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_mem_re),
    .i_idx   (r_mem_idx),
    .o_valid (w_cap_valid),
    .o_idx   (w_cap_idx)
  );

  assign w_cap_last = w_cap_valid && (w_cap_idx == lane_idx_t'(LANES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_n;
  end

  // NOTE: every variable gets a default before the case so no path leaves a latch behind.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_n = ISSUE;
          w_cnt_n   = '0;
          w_accept  = 1'b1;
        end
      end
      ISSUE: begin
        if (r_cnt == lane_idx_t'(LANES - 1)) begin
          w_state_n = r_write ? DONE : DRAIN;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + lane_idx_t'(1);
        end
      end
      DRAIN: begin
        if (w_cap_last) w_state_n = DONE;
      end
      DONE: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    w_base_sel    = w_accept ? req_addr  : r_base;
    w_write_sel   = w_accept ? req_write : r_write;
    w_wdata_sel   = w_accept ? req_wdata : r_wdata;
    w_issue_n     = (w_state_n == ISSUE);
    w_mem_re_n    = w_issue_n && !w_write_sel;
    w_mem_we_n    = w_issue_n && w_write_sel;
    w_mem_addr_n  = w_issue_n ? (w_base_sel + AW'(w_cnt_n)) : '0;
    w_mem_wdata_n = w_mem_we_n ? w_wdata_sel[lane_of(w_cnt_n)] : '0;
    w_rsp_valid_n = (w_state_n == DONE);
    w_stall_n     = (w_state_n != IDLE);
    w_req_ready_n = (w_state_n == IDLE);
  end

  always_comb begin
    w_shadow_n = r_shadow;
    if (w_cap_valid) w_shadow_n[lane_of(w_cap_idx)] = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_base      <= '0;
      r_write     <= 1'b0;
      r_req_ready <= 1'b1;
      r_stall     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_idx   <= '0;
    end else begin
      r_cnt       <= w_cnt_n;
      r_req_ready <= w_req_ready_n;
      r_stall     <= w_stall_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_re    <= w_mem_re_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_mem_idx   <= w_cnt_n;
      if (w_accept) begin
        r_base  <= req_addr;
        r_write <= req_write;
      end
      // The last lane lands in the same cycle DONE is entered, so publish the merged shadow.
      if (r_state == DRAIN && w_state_n == DONE) r_rsp_rdata <= w_shadow_n;
    end
  end

  always_ff @(posedge clk) begin
    r_shadow <= w_shadow_n;
    if (w_accept) r_wdata <= req_wdata;
  end

  assign req_ready = r_req_ready;
  assign stall     = r_stall;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer: two instances (RD_LAT=1 and RD_LAT=3) share stimulus,
// each with its own word RAM model; expected values are hand-derived timings and data.
module tb_vec_mem_sequencer;
  import vec_mem_pkg::*;

  typedef logic [511:0] word_t;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  lane_vec_t     req_wdata;

  logic          req_ready1, rsp_valid1, stall1, mem_re1, mem_we1;
  lane_vec_t     rsp_rdata1;
  logic [AW-1:0] mem_addr1;
  logic [DW-1:0] mem_wdata1, mem_rdata1;

  logic          req_ready3, rsp_valid3, stall3, mem_re3, mem_we3;
  lane_vec_t     rsp_rdata3;
  logic [AW-1:0] mem_addr3;
  logic [DW-1:0] mem_wdata3, mem_rdata3;

  int n_total;
  int n_bad;

  logic          pl_en;
  logic [11:0]   pl_addr;
  logic [DW-1:0] pl_data;

  logic [DW-1:0]          ram1 [4096];
  logic [DW-1:0]          ram3 [4096];
  logic [DW-1:0]          d1;
  logic [2:0][DW-1:0]     d3;

  lane_vec_t vec_a, vec_b, exp_load;
  logic [55:0] obs_ready, obs_re, obs_we, obs_rsp;
  logic [55:0] exp_ready, exp_re, exp_we, exp_rsp;
  int n_events;
  int n_both;

  vec_mem_sequencer #(.RD_LAT(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready1),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid1),
    .rsp_rdata (rsp_rdata1),
    .stall     (stall1),
    .mem_addr  (mem_addr1),
    .mem_re    (mem_re1),
    .mem_we    (mem_we1),
    .mem_wdata (mem_wdata1),
    .mem_rdata (mem_rdata1)
  );

  vec_mem_sequencer #(.RD_LAT(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready3),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid3),
    .rsp_rdata (rsp_rdata3),
    .stall     (stall3),
    .mem_addr  (mem_addr3),
    .mem_re    (mem_re3),
    .mem_we    (mem_we3),
    .mem_wdata (mem_wdata3),
    .mem_rdata (mem_rdata3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models; unread cycles return a marker so stray captures corrupt the result.
  always @(posedge clk) begin
    if (pl_en)        ram1[pl_addr] <= pl_data;
    else if (mem_we1) ram1[mem_addr1[11:0]] <= mem_wdata1;
    d1 <= mem_re1 ? ram1[mem_addr1[11:0]] : 32'hDEADBEEF;
  end
  assign mem_rdata1 = d1;

  always @(posedge clk) begin
    if (pl_en)        ram3[pl_addr] <= pl_data;
    else if (mem_we3) ram3[mem_addr3[11:0]] <= mem_wdata3;
    d3 <= {d3[1:0], (mem_re3 ? ram3[mem_addr3[11:0]] : 32'hDEADBEEF)};
  end
  assign mem_rdata3 = d3[2];

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of the accept cycle t0; returns at the negedge of t0+1.
  task automatic issue(input string tn, input logic wr, input logic [AW-1:0] a, input lane_vec_t d);
    check({tn, " ready"}, word_t'({req_ready1, req_ready3}), word_t'(2'b11));
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_store(input string tn, input logic [AW-1:0] base, input lane_vec_t d);
    issue(tn, 1'b1, base, d);
    for (int k = 0; k < LANES; k++) begin
      check({tn, " strb1"}, word_t'({mem_re1, mem_we1, stall1, rsp_valid1}), word_t'(4'b0110));
      check({tn, " addr1"}, word_t'(mem_addr1), word_t'(AW'(base + AW'(k))));
      check({tn, " wdat1"}, word_t'(mem_wdata1), word_t'(d[LANES-1-k]));
      check({tn, " strb3"}, word_t'({mem_re3, mem_we3, mem_addr3}), word_t'({2'b01, AW'(base + AW'(k))}));
      @(negedge clk);
    end
    check({tn, " done"}, word_t'({rsp_valid1, rsp_valid3, stall1, mem_we1}), word_t'(4'b1110));
    @(negedge clk);
    check({tn, " idle"}, word_t'({rsp_valid1, rsp_valid3, req_ready1, req_ready3, stall1}),
          word_t'(5'b00110));
  endtask

  task automatic run_load(input string tn, input logic [AW-1:0] base, input lane_vec_t expv);
    issue(tn, 1'b0, base, '0);
    for (int k = 0; k < LANES; k++) begin
      check({tn, " strb1"}, word_t'({mem_re1, mem_we1, stall1, rsp_valid1}), word_t'(4'b1010));
      check({tn, " addr1"}, word_t'(mem_addr1), word_t'(AW'(base + AW'(k))));
      check({tn, " strb3"}, word_t'({mem_re3, mem_we3, mem_addr3}), word_t'({2'b10, AW'(base + AW'(k))}));
      @(negedge clk);
    end
    // t0+17
    check({tn, " t17"}, word_t'({rsp_valid1, stall1, mem_re1, mem_re3}), word_t'(4'b0100));
    @(negedge clk);
    // t0+18
    check({tn, " t18"}, word_t'({rsp_valid1, stall1, rsp_valid3}), word_t'(3'b110));
    check({tn, " data1"}, word_t'(rsp_rdata1), word_t'(expv));
    @(negedge clk);
    // t0+19
    check({tn, " t19"}, word_t'({rsp_valid1, stall1, req_ready1, rsp_valid3, stall3}), word_t'(5'b00101));
    @(negedge clk);
    // t0+20
    check({tn, " t20"}, word_t'({rsp_valid3, stall3}), word_t'(2'b11));
    check({tn, " data3"}, word_t'(rsp_rdata3), word_t'(expv));
    @(negedge clk);
    // t0+21
    check({tn, " t21"}, word_t'({rsp_valid3, stall3, req_ready3}), word_t'(3'b001));
    check({tn, " hold1"}, word_t'(rsp_rdata1), word_t'(expv));
    check({tn, " hold3"}, word_t'(rsp_rdata3), word_t'(expv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
    for (int i = 0; i < LANES; i++) begin
      vec_a[i]    = DW'(32'hA000 + i);
      vec_b[i]    = DW'(32'hC0DE0000 + i * 17);
      exp_load[LANES-1-i] = DW'(i * 3);
    end

    repeat (3) @(negedge clk);
    check("rst ctl1", word_t'({req_ready1, stall1, rsp_valid1, mem_re1, mem_we1}), word_t'(5'b10000));
    check("rst dat1", word_t'({mem_addr1, mem_wdata1}), word_t'(0));
    check("rst rsp1", word_t'(rsp_rdata1), word_t'(0));
    check("rst ctl3", word_t'({req_ready3, stall3, rsp_valid3, mem_re3, mem_we3}), word_t'(5'b10000));
    rst = 1'b1;

    for (int k = 0; k < LANES; k++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = 12'(12'h200 + k);
      pl_data = DW'(k * 3);
    end
    @(negedge clk);
    pl_en = 1'b0;
    @(negedge clk);

    // 1: store
    run_store("t1", 21'h000100, vec_a);
    check("t1 rsp1 kept", word_t'(rsp_rdata1), word_t'(0));
    check("t1 rsp3 kept", word_t'(rsp_rdata3), word_t'(0));

    // 2 + 3: load, both latencies
    run_load("t2", 21'h000200, exp_load);

    // 4: address wrap
    run_store("t4", 21'h1FFFF8, vec_b);
    check("t4 rsp kept", word_t'(rsp_rdata1), word_t'(exp_load));

    // 5: reset in the middle of a load
    issue("t5", 1'b0, 21'h000200, '0);
    repeat (5) @(negedge clk);
    check("t5 pre", word_t'({mem_re1, mem_re3, stall1}), word_t'(3'b111));
    rst = 1'b0;
    #1;
    check("t5 ctl", word_t'({mem_re1, mem_re3, stall1, stall3, req_ready1, req_ready3, rsp_valid1}),
          word_t'(7'b0000110));
    check("t5 rdat1", word_t'(rsp_rdata1), word_t'(0));
    check("t5 rdat3", word_t'(rsp_rdata3), word_t'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_events = 0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid1 || rsp_valid3 || mem_re1 || mem_re3 || mem_we1 || mem_we3) n_events++;
    end
    check("t5 quiet", word_t'(n_events), word_t'(0));
    run_load("t5b", 21'h000200, exp_load);

    // 6: request held high, alternating store/load/store
    n_both    = 0;
    req_valid = 1'b1;
    req_addr  = 21'h000300;
    req_wdata = vec_b;
    for (int c = 0; c < 56; c++) begin
      obs_ready[c] = req_ready1;
      obs_re[c]    = mem_re1;
      obs_we[c]    = mem_we1;
      obs_rsp[c]   = rsp_valid1;
      if ((mem_re1 && mem_we1) || (mem_re3 && mem_we3)) n_both++;
      exp_ready[c] = (c == 0) || (c == 18) || (c == 37) || (c == 55);
      exp_we[c]    = (c >= 1 && c <= 16) || (c >= 38 && c <= 53);
      exp_re[c]    = (c >= 19 && c <= 34);
      exp_rsp[c]   = (c == 17) || (c == 36) || (c == 54);
      if (c == 55) req_valid = 1'b0;
      else         req_write = (c < 18) || (c >= 37);
      @(negedge clk);
    end
    repeat (25) begin
      @(negedge clk);
      if ((mem_re1 && mem_we1) || (mem_re3 && mem_we3)) n_both++;
    end
    check("t6 ready", word_t'(obs_ready), word_t'(exp_ready));
    check("t6 re", word_t'(obs_re), word_t'(exp_re));
    check("t6 we", word_t'(obs_we), word_t'(exp_we));
    check("t6 rsp", word_t'(obs_rsp), word_t'(exp_rsp));
    check("t6 re&we", word_t'(n_both), word_t'(0));
    check("t6 data1", word_t'(rsp_rdata1), word_t'(vec_b));
    check("t6 data3", word_t'(rsp_rdata3), word_t'(vec_b));
    check("t6 idle", word_t'({req_ready1, req_ready3, stall1, stall3}), word_t'(4'b1100));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
